sd_image_loader: RTL and testbench



---
 rtl/sd_image_loader_pkg.sv | 32 +++
 rtl/sd_image_loader_edge.sv | 25 ++
 rtl/sd_image_loader.sv | 126 ++++++++++++
 tb/tb_sd_image_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_image_loader_pkg.sv
// Shared definitions for the SD-card image loader and the frame buffer it feeds.
// Holds the loader state encoding, image geometry and the 4-bit colour codes.
package sd_image_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_ISSUE,
        ST_RECV,
        ST_NEXT,
        ST_DONE
    } loader_state_t;

    localparam int SECTOR_BYTES   = 512;
    localparam int IMAGE_WIDTH    = 640;
    localparam int IMAGE_HEIGHT   = 360;
    localparam int IMAGE_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PIX_WIDTH      = 4;
    localparam int TIMEOUT_CYCLES = 1 << 20;

    // Colour codes stored in the frame buffer, one nibble per pixel
    localparam logic [3:0] COLOR_BLACK   = 4'h0;
    localparam logic [3:0] COLOR_RED     = 4'h1;
    localparam logic [3:0] COLOR_GREEN   = 4'h2;
    localparam logic [3:0] COLOR_BLUE    = 4'h3;
    localparam logic [3:0] COLOR_YELLOW  = 4'h4;
    localparam logic [3:0] COLOR_CYAN    = 4'h5;
    localparam logic [3:0] COLOR_MAGENTA = 4'h6;
    localparam logic [3:0] COLOR_GREY    = 4'h7;
    localparam logic [3:0] COLOR_WHITE   = 4'hF;

endpackage

// File: rtl/sd_image_loader_edge.sv
// Rising-edge detector for the sd_controller byte strobe.
// The history register always tracks the strobe; only the accept pulse is gated.
module sd_byte_edge
    import sd_image_loader_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic byte_available,
    input  logic enable,
    output logic accept
);

    logic byte_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_prev <= 1'b0;
        end else begin
            byte_prev <= byte_available;
        end
    end

    assign accept = enable && byte_available && !byte_prev;

endmodule

// File: rtl/sd_image_loader.sv
// Streams one image from the SD card into the frame buffer write port,
// stepping sector addresses, draining tail bytes and enforcing a watchdog.
module sd_image_loader #(
    parameter int SECTOR_BYTES   = sd_image_loader_pkg::SECTOR_BYTES,
    parameter int IMAGE_PIXELS   = sd_image_loader_pkg::IMAGE_PIXELS,
    parameter int PIX_WIDTH      = sd_image_loader_pkg::PIX_WIDTH,
    parameter int TIMEOUT_CYCLES = sd_image_loader_pkg::TIMEOUT_CYCLES
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            start_in,
    input  logic [31:0]                     base_addr_in,
    input  logic                            abort_in,
    input  logic                            sd_ready_in,
    input  logic                            sd_byte_available_in,
    input  logic [7:0]                      sd_dout_in,
    output logic                            sd_rd_out,
    output logic [31:0]                     sd_addr_out,
    output logic [$clog2(IMAGE_PIXELS)-1:0] buf_addr_out,
    output logic [PIX_WIDTH-1:0]            buf_data_out,
    output logic                            buf_we_out,
    output logic                            busy_out,
    output logic                            done_out,
    output logic                            error_out
);
    import sd_image_loader_pkg::*;

    localparam int ADDR_W = $clog2(IMAGE_PIXELS);
    localparam int PIX_W  = $clog2(IMAGE_PIXELS + 1);
    localparam int BYTE_W = $clog2(SECTOR_BYTES);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t    state, state_next;
    logic             accept, recv_enable, watched, timeout;
    logic [PIX_W-1:0] pix_idx;
    logic [BYTE_W-1:0] byte_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             unused_dout_bits;

    assign unused_dout_bits = ^sd_dout_in[7:PIX_WIDTH];

    // Abort wins over a byte edge in the same cycle, so that byte is never accepted
    assign recv_enable = (state == ST_RECV) && !abort_in;

    sd_byte_edge u_edge (
        .clk            (clk_in),
        .rst_n          (rst_n_in),
        .byte_available (sd_byte_available_in),
        .enable         (recv_enable),
        .accept         (accept)
    );

    assign watched  = (state == ST_WAIT_READY) || (state == ST_ISSUE) || (state == ST_RECV);
    assign timeout  = watched && !accept && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign busy_out = (state != ST_IDLE);
    assign done_out = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (start_in) state_next = ST_WAIT_READY;
            ST_WAIT_READY: if (sd_ready_in) state_next = ST_ISSUE;
            ST_ISSUE:      if (!sd_ready_in) state_next = ST_RECV;
            ST_RECV:       if (accept && (byte_cnt == BYTE_W'(SECTOR_BYTES - 1))) state_next = ST_NEXT;
            ST_NEXT:       state_next = (pix_idx == PIX_W'(IMAGE_PIXELS)) ? ST_DONE : ST_WAIT_READY;
            ST_DONE:       state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
        if ((state != ST_IDLE) && (abort_in || timeout)) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state        <= ST_IDLE;
            sd_rd_out    <= 1'b0;
            sd_addr_out  <= '0;
            buf_addr_out <= '0;
            buf_data_out <= '0;
            buf_we_out   <= 1'b0;
            error_out    <= 1'b0;
            pix_idx      <= '0;
            byte_cnt     <= '0;
            wd_cnt       <= '0;
        end else begin
            state      <= state_next;
            sd_rd_out  <= (state_next == ST_ISSUE);
            buf_we_out <= 1'b0;

            if ((state == ST_IDLE) && start_in) begin
                sd_addr_out <= base_addr_in;
                pix_idx     <= '0;
                byte_cnt    <= '0;
                error_out   <= 1'b0;
            end

            // Bytes past the last pixel are counted but drained without a write
            if (accept) begin
                byte_cnt <= byte_cnt + BYTE_W'(1);
                if (pix_idx < PIX_W'(IMAGE_PIXELS)) begin
                    buf_we_out   <= 1'b1;
                    buf_addr_out <= pix_idx[ADDR_W-1:0];
                    buf_data_out <= sd_dout_in[PIX_WIDTH-1:0];
                    pix_idx      <= pix_idx + PIX_W'(1);
                end
            end

            if (state == ST_NEXT) begin
                sd_addr_out <= sd_addr_out + 32'(SECTOR_BYTES);
                byte_cnt    <= '0;
            end

            if (timeout) begin
                error_out <= 1'b1;
            end

            if ((state_next != state) || accept || !watched) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sd_image_loader.sv
// Bench for sd_image_loader: two instances (1024 and 700 pixels) fed in lockstep
// by a small SD controller model, covering sectors, drain, timeout, abort and reset.
module tb_sd_image_loader;

    localparam int SB    = 512;
    localparam int PIX_A = 1024;
    localparam int PIX_B = 700;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        abort = 1'b0;
    logic        sd_ready = 1'b1;
    logic        byte_av = 1'b0;
    logic [7:0]  dout = '0;

    logic        rd_a, we_a, busy_a, done_a, err_a;
    logic [31:0] addr_a;
    logic [$clog2(PIX_A)-1:0] baddr_a;
    logic [3:0]  bdata_a;
    logic        rd_b, we_b, busy_b, done_b, err_b;
    logic [31:0] addr_b;
    logic [$clog2(PIX_B)-1:0] baddr_b;
    logic [3:0]  bdata_b;

    int checks = 0;
    int failures = 0;
    int wr_a = 0, wr_b = 0, dn_a = 0, dn_b = 0;

    typedef struct {
        logic [7:0] dout;
        logic [3:0] exp_data;
    } vec_t;
    vec_t table_v[12];

    always #20 clk = ~clk;

    sd_image_loader #(.SECTOR_BYTES(SB), .IMAGE_PIXELS(PIX_A), .PIX_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .base_addr_in(base_addr),
        .abort_in(abort), .sd_ready_in(sd_ready), .sd_byte_available_in(byte_av), .sd_dout_in(dout),
        .sd_rd_out(rd_a), .sd_addr_out(addr_a), .buf_addr_out(baddr_a), .buf_data_out(bdata_a),
        .buf_we_out(we_a), .busy_out(busy_a), .done_out(done_a), .error_out(err_a)
    );

    sd_image_loader #(.SECTOR_BYTES(SB), .IMAGE_PIXELS(PIX_B), .PIX_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .base_addr_in(base_addr),
        .abort_in(abort), .sd_ready_in(sd_ready), .sd_byte_available_in(byte_av), .sd_dout_in(dout),
        .sd_rd_out(rd_b), .sd_addr_out(addr_b), .buf_addr_out(baddr_b), .buf_data_out(bdata_b),
        .buf_we_out(we_b), .busy_out(busy_b), .done_out(done_b), .error_out(err_b)
    );

    always @(negedge clk) begin
        if (we_a) wr_a++;
        if (we_b) wr_b++;
        if (done_a) dn_a++;
        if (done_b) dn_b++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one byte strobe high for a cycle; returns at the negedge after the accept edge
    task automatic applyStimulus(input logic [7:0] b);
        dout = b;
        byte_av = 1'b1;
        @(negedge clk);
        byte_av = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rd"},    32'(rd_a),    32'd0);
        checkOutput({tag, "_addr"},  addr_a,       32'd0);
        checkOutput({tag, "_baddr"}, 32'(baddr_a), 32'd0);
        checkOutput({tag, "_bdata"}, 32'(bdata_a), 32'd0);
        checkOutput({tag, "_we"},    32'(we_a),    32'd0);
        checkOutput({tag, "_busy"},  32'(busy_a),  32'd0);
        checkOutput({tag, "_done"},  32'(done_a),  32'd0);
        checkOutput({tag, "_err"},   32'(err_a),   32'd0);
        checkOutput({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    endtask

    task automatic pulseStart(input logic [31:0] base, input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        base_addr = 32'hDEAD_0000;
    endtask

    // One sector as the SD controller model: wait for the read, drop ready, stream nbytes
    task automatic runSector(input int sector, input logic [31:0] exp_addr, input int nbytes,
                             input int abort_at, input bit use_table, input bit inject_start);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_a) begin ok = 1'b1; break; end
        end
        checkOutput("rd_issued", 32'(ok), 32'd1);
        checkOutput("sd_addr_a", addr_a, exp_addr);
        checkOutput("sd_addr_b", addr_b, exp_addr);
        if (!ok) return;
        sd_ready = 1'b0;
        @(negedge clk);
        checkOutput("rd_released", 32'(rd_a), 32'd0);
        for (int k = 0; k < nbytes; k++) begin
            int idx = sector * SB + k;
            logic [7:0] b;
            logic [3:0] e;
            if (idx == abort_at) begin
                abort = 1'b1;
                dout = 8'h5C;
                byte_av = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                byte_av = 1'b0;
                checkOutput("abort_we_a", 32'(we_a), 32'd0);
                checkOutput("abort_we_b", 32'(we_b), 32'd0);
                checkOutput("abort_busy", 32'(busy_a), 32'd0);
                checkOutput("abort_rd", 32'(rd_a), 32'd0);
                checkOutput("abort_err", 32'(err_a), 32'd0);
                sd_ready = 1'b1;
                return;
            end
            if (use_table && idx < 12) begin
                b = table_v[idx].dout;
                e = table_v[idx].exp_data;
            end else begin
                b = 8'(idx);
                e = 4'(idx);
            end
            applyStimulus(b);
            checkOutput("we_a", 32'(we_a), 32'd1);
            checkOutput("baddr_a", 32'(baddr_a), 32'(idx));
            checkOutput("bdata_a", 32'(bdata_a), 32'(e));
            if (idx < PIX_B) begin
                checkOutput("we_b", 32'(we_b), 32'd1);
                checkOutput("baddr_b", 32'(baddr_b), 32'(idx));
                checkOutput("bdata_b", 32'(bdata_b), 32'(e));
            end else begin
                checkOutput("drain_we_b", 32'(we_b), 32'd0);
            end
            if (inject_start && k == 100) begin
                start = 1'b1;
                base_addr = 32'h0000_8000;
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (nbytes == SB) sd_ready = 1'b1;
    endtask

    task automatic waitDone(input logic [31:0] exp_end_addr);
        bit ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_a) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("done_seen", 32'(ok), 32'd1);
        checkOutput("done_b_lockstep", 32'(done_b), 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done_a), 32'd0);
        checkOutput("busy_after_done", 32'(busy_a), 32'd0);
        checkOutput("end_addr", addr_a, exp_end_addr);
    endtask

    initial begin
        int wa0, wb0, da0, n;
        bit seen;
        table_v[0]  = '{8'h00, 4'h0};
        table_v[1]  = '{8'h09, 4'h9};
        table_v[2]  = '{8'h0F, 4'hF};
        table_v[3]  = '{8'h10, 4'h0};
        table_v[4]  = '{8'h3C, 4'hC};
        table_v[5]  = '{8'hA5, 4'h5};
        table_v[6]  = '{8'hF9, 4'h9};
        table_v[7]  = '{8'hFF, 4'hF};
        table_v[8]  = '{8'h7E, 4'hE};
        table_v[9]  = '{8'h81, 4'h1};
        table_v[10] = '{8'h5A, 4'hA};
        table_v[11] = '{8'hC3, 4'h3};

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full two-sector load; a second start mid-sector must be ignored
        $display("[TB] full load from 0x1000");
        wa0 = wr_a; wb0 = wr_b; da0 = dn_a;
        pulseStart(32'h0000_1000, 1'b0);
        checkOutput("busy_after_start", 32'(busy_a), 32'd1);
        runSector(0, 32'h0000_1000, SB, -1, 1'b0, 1'b1);
        runSector(1, 32'h0000_1200, SB, -1, 1'b0, 1'b0);
        waitDone(32'h0000_1400);
        checkOutput("writes_a", 32'(wr_a - wa0), 32'd1024);
        checkOutput("writes_b", 32'(wr_b - wb0), 32'd700);
        checkOutput("done_count", 32'(dn_a - da0), 32'd1);
        checkOutput("done_count_b", 32'(dn_b - da0), 32'd1);

        // Stall mid-sector until the watchdog fires
        $display("[TB] watchdog stall");
        da0 = dn_a;
        pulseStart(32'h0000_2000, 1'b0);
        runSector(0, 32'h0000_2000, 10, -1, 1'b0, 1'b0);
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (err_a) begin seen = 1'b1; break; end
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_seen", 32'(seen), 32'd1);
        checkOutput("timeout_cycle", 32'(n), 32'd64);
        checkOutput("timeout_err_b", 32'(err_b), 32'd1);
        checkOutput("timeout_busy", 32'(busy_a), 32'd0);
        checkOutput("timeout_rd", 32'(rd_a), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("err_sticky", 32'(err_a), 32'd1);
        checkOutput("timeout_no_done", 32'(dn_a - da0), 32'd0);
        sd_ready = 1'b1;

        // Start together with abort in IDLE: start wins and clears the error
        $display("[TB] abort on byte edge at pixel 300");
        wa0 = wr_a; wb0 = wr_b;
        pulseStart(32'h0000_3000, 1'b1);
        checkOutput("start_beats_abort", 32'(busy_a), 32'd1);
        checkOutput("err_cleared", 32'(err_a), 32'd0);
        runSector(0, 32'h0000_3000, SB, 300, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_writes_a", 32'(wr_a - wa0), 32'd300);
        checkOutput("abort_writes_b", 32'(wr_b - wb0), 32'd300);
        checkOutput("abort_no_done", 32'(dn_a - da0), 32'd0);

        // Restart rewrites from address 0 with table-driven data
        $display("[TB] restart after abort");
        wa0 = wr_a; wb0 = wr_b; da0 = dn_a;
        pulseStart(32'h0000_4000, 1'b0);
        runSector(0, 32'h0000_4000, SB, -1, 1'b1, 1'b0);
        runSector(1, 32'h0000_4200, SB, -1, 1'b1, 1'b0);
        waitDone(32'h0000_4400);
        checkOutput("restart_writes_a", 32'(wr_a - wa0), 32'd1024);
        checkOutput("restart_writes_b", 32'(wr_b - wb0), 32'd700);
        checkOutput("restart_done", 32'(dn_a - da0), 32'd1);

        // Reset while the read request is held in ISSUE
        $display("[TB] reset during issue");
        da0 = dn_a;
        pulseStart(32'h0000_5000, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_a) begin seen = 1'b1; break; end
        end
        checkOutput("issue_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset_issue");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_no_done", 32'(dn_a - da0), 32'd0);
        checkOutput("reset_stays_idle", 32'(busy_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
